// File: rtl/snitch_tcdm_pkg.sv
// Shared types for the TCDM bank adapter: bank request/response structs and the AMO opcode set.
// amo_alu computes the 32-bit result of one atomic applied to a single word half.
package snitch_tcdm_pkg;

   localparam int unsigned AddrWidth = 32;
   localparam int unsigned DataWidth = 64;
   localparam int unsigned StrbWidth = DataWidth / 8;
   localparam int unsigned UserWidth = 8;
   localparam int unsigned AmoWidth  = 32;

   typedef enum logic [3:0] {
      AMONone = 4'h0,
      AMOSwap = 4'h1,
      AMOAdd  = 4'h2,
      AMOAnd  = 4'h3,
      AMOOr   = 4'h4,
      AMOXor  = 4'h5,
      AMOMax  = 4'h6,
      AMOMaxu = 4'h7,
      AMOMin  = 4'h8,
      AMOMinu = 4'h9,
      AMOLR   = 4'hA,
      AMOSC   = 4'hB
   } amo_op_e;

   typedef logic [UserWidth-1:0] user_t;

   typedef struct packed {
      logic [AddrWidth-1:0] addr;
      logic                 write;
      amo_op_e              amo;
      logic [DataWidth-1:0] data;
      logic [StrbWidth-1:0] strb;
      user_t                user;
   } mem_req_chan_t;

   typedef struct packed {
      mem_req_chan_t q;
      logic          q_valid;
   } mem_req_t;

   typedef struct packed {
      logic [DataWidth-1:0] data;
      user_t                user;
   } mem_rsp_chan_t;

   typedef struct packed {
      mem_rsp_chan_t p;
      logic          q_ready;
   } mem_rsp_t;

   function automatic logic [AmoWidth-1:0] amo_alu(amo_op_e op,
                                                   logic [AmoWidth-1:0] old,
                                                   logic [AmoWidth-1:0] operand);
      logic [AmoWidth-1:0] res;
      res = old;
      case (op)
         AMOSwap: res = operand;
         AMOAdd:  res = old + operand;
         AMOAnd:  res = old & operand;
         AMOOr:   res = old | operand;
         AMOXor:  res = old ^ operand;
         AMOMax:  res = ($signed(old) > $signed(operand)) ? old : operand;
         AMOMin:  res = ($signed(old) < $signed(operand)) ? old : operand;
         AMOMaxu: res = (old > operand) ? old : operand;
         AMOMinu: res = (old < operand) ? old : operand;
         default: res = old;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/snitch_tcdm_bank_adapter_if.sv
// Bank-port bundle between the TCDM interconnect (master) and one bank adapter (slave).
interface snitch_tcdm_bank_adapter_if;
   import snitch_tcdm_pkg::*;

   mem_req_t req;
   mem_rsp_t rsp;

   modport master (output req, input rsp);
   modport slave  (input req, output rsp);

endinterface

// File: rtl/snitch_amo_alu.sv
// Combinational AMO datapath: merges the atomic result into the addressed 32-bit half of the old word.
module snitch_amo_alu
   import snitch_tcdm_pkg::*;
(
   input  amo_op_e              op_i,
   input  logic [DataWidth-1:0] old_i,
   input  logic [DataWidth-1:0] operand_i,
   input  logic [StrbWidth-1:0] strb_i,
   output logic [DataWidth-1:0] wdata_o,
   output logic [StrbWidth-1:0] be_o
);

   logic writes;

   // LR and SC never modify memory; any strobe other than a clean half disables the write.
   assign writes = !(op_i inside {AMONone, AMOLR, AMOSC});

   always_comb begin
      wdata_o = old_i;
      be_o    = '0;
      if (writes) begin
         if (strb_i == 8'h0F) begin
            wdata_o[AmoWidth-1:0] = amo_alu(op_i, old_i[AmoWidth-1:0], operand_i[AmoWidth-1:0]);
            be_o                  = strb_i;
         end else if (strb_i == 8'hF0) begin
            wdata_o[DataWidth-1:AmoWidth] = amo_alu(op_i, old_i[DataWidth-1:AmoWidth],
                                                    operand_i[DataWidth-1:AmoWidth]);
            be_o                          = strb_i;
         end
      end
   end

endmodule

// File: rtl/snitch_tcdm_bank_adapter.sv
// Per-bank TCDM stage: drives a single-port SRAM, runs AMOs as a read then write-back cycle,
// and returns the old word at a fixed RspLatency regardless of access type.
module snitch_tcdm_bank_adapter
   import snitch_tcdm_pkg::*;
#(
   parameter int unsigned RspLatency = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   snitch_tcdm_bank_adapter_if.slave tcdm,
   output logic                    sram_req_o,
   output logic                    sram_we_o,
   output logic [AddrWidth-1:0]    sram_addr_o,
   output logic [DataWidth-1:0]    sram_wdata_o,
   output logic [StrbWidth-1:0]    sram_be_o,
   input  logic [DataWidth-1:0]    sram_rdata_i
);

   typedef enum logic {IDLE, AMO_WB} state_e;

   state_e               state_q, state_d;
   logic [AddrWidth-1:0] addr_q, addr_d;
   logic [DataWidth-1:0] operand_q, operand_d;
   logic [StrbWidth-1:0] strb_q, strb_d;
   amo_op_e              amo_q, amo_d;
   user_t                user_q, user_d;
   logic                 sc_q, sc_d;

   logic                 is_rmw;
   logic                 q_ready;
   logic [DataWidth-1:0] amo_wdata;
   logic [StrbWidth-1:0] amo_be;
   logic [DataWidth-1:0] stage1_data;
   logic [DataWidth-1:0] rsp_data;
   user_t                rsp_user;
   mem_rsp_t             mem_rsp;

   assign is_rmw = !(tcdm.req.q.amo inside {AMONone, AMOLR});

   snitch_amo_alu i_amo_alu (
      .op_i      (amo_q),
      .old_i     (sram_rdata_i),
      .operand_i (operand_q),
      .strb_i    (strb_q),
      .wdata_o   (amo_wdata),
      .be_o      (amo_be)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      operand_d    = operand_q;
      strb_d       = strb_q;
      amo_d        = amo_q;
      user_d       = user_q;
      sc_d         = 1'b0;
      q_ready      = 1'b1;
      sram_req_o   = 1'b0;
      sram_we_o    = 1'b0;
      sram_addr_o  = tcdm.req.q.addr;
      sram_wdata_o = tcdm.req.q.data;
      sram_be_o    = tcdm.req.q.strb;
      case (state_q)
         IDLE: begin
            if (tcdm.req.q_valid) begin
               sram_req_o = 1'b1;
               user_d     = tcdm.req.q.user;
               sc_d       = (tcdm.req.q.amo == AMOSC);
               if (is_rmw) begin
                  addr_d    = tcdm.req.q.addr;
                  operand_d = tcdm.req.q.data;
                  strb_d    = tcdm.req.q.strb;
                  amo_d     = tcdm.req.q.amo;
                  state_d   = AMO_WB;
               end else begin
                  sram_we_o = tcdm.req.q.write && (tcdm.req.q.amo == AMONone);
               end
            end
         end
         AMO_WB: begin
            q_ready      = 1'b0;
            sram_req_o   = 1'b1;
            sram_we_o    = 1'b1;
            sram_addr_o  = addr_q;
            sram_wdata_o = amo_wdata;
            sram_be_o    = amo_be;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset aborts a pending write-back; the atomic is simply lost.
      if (rst_i) begin
         sram_req_o = 1'b0;
         q_ready    = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         operand_q <= '0;
         strb_q    <= '0;
         amo_q     <= AMONone;
         user_q    <= '0;
         sc_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         operand_q <= operand_d;
         strb_q    <= strb_d;
         amo_q     <= amo_d;
         user_q    <= user_d;
         sc_q      <= sc_d;
      end
   end

   // A store-conditional always reports failure instead of the SRAM word.
   assign stage1_data = sc_q ? DataWidth'(1) : sram_rdata_i;

   if (RspLatency == 2) begin : g_lat2
      logic [DataWidth-1:0] data_q, data_d;
      user_t                user2_q, user2_d;

      always_comb begin
         data_d  = stage1_data;
         user2_d = user_q;
      end

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            data_q  <= '0;
            user2_q <= '0;
         end else begin
            data_q  <= data_d;
            user2_q <= user2_d;
         end
      end

      assign rsp_data = data_q;
      assign rsp_user = user2_q;
   end else begin : g_lat1
      assign rsp_data = stage1_data;
      assign rsp_user = user_q;
   end

   always_comb begin
      mem_rsp         = '0;
      mem_rsp.q_ready = q_ready;
      if (!rst_i) begin
         mem_rsp.p.data = rsp_data;
         mem_rsp.p.user = rsp_user;
      end
   end

   assign tcdm.rsp = mem_rsp;

endmodule
